// File: rtl/light_hash_param.sv
// light_hash_param
//   Byte-serial light-weight hash core. Message bytes arrive framed by
//   HEAD_BYTE / TAIL_BYTE. Each data byte is absorbed over ROUNDS clock
//   cycles. In every cycle all NUM_BLOCKS 8-bit lanes update in parallel
//   through one AES S-box lookup per lane. When the tail marker arrives,
//   the digest is presented until the consumer acknowledges it.
//
// Optional feature (macro LH_MSG_LEN_EN):
//   When defined, adds output msg_len[15:0]. It is a saturating count of the
//   data bytes absorbed in the current message.
//
// Ports:
//   clk              in   clock
//   rst_n            in   asynchronous active-low reset
//   in_byte[7:0]     in   message byte
//   in_valid         in   in_byte valid
//   in_ready         out  core accepts a byte this cycle
//   digest[8N-1:0]   out  digest[8j+:8] = H[j]; zero unless digest_valid
//   digest_valid     out  digest stable and valid
//   digest_ack       in   consumer takes the digest
//   busy             out  high while absorbing a data byte
//   err_invalid_byte out  one-cycle pulse after an invalid byte is accepted
//   msg_len[15:0]    out  (LH_MSG_LEN_EN only) data bytes in current message

module light_hash_param #(
    parameter int                        NUM_BLOCKS = 8,
    parameter int                        ROUNDS     = 32,
    parameter logic [7:0]                HEAD_BYTE  = 8'hFF,
    parameter logic [7:0]                TAIL_BYTE  = 8'h00,
    parameter logic [8*NUM_BLOCKS-1:0]   INIT_VALUE = {NUM_BLOCKS{8'h00}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   in_byte,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [8*NUM_BLOCKS-1:0]      digest,
    output logic                         digest_valid,
    input  logic                         digest_ack,
    output logic                         busy,
    output logic                         err_invalid_byte
`ifdef LH_MSG_LEN_EN
    ,
    output logic [15:0]                  msg_len
`endif
);

    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ROUNDS - 1);

    // AES S-box. Entry 0 sits in the most significant byte, so entry t lives
    // at bit offset 8*(255-t) = {~t, 3'b000}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_ABSORB = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] t);
        logic [10:0] base;
        base = {~t, 3'b000};
        return SBOX_TABLE[base +: 8];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // The framing markers are always legal, even if configured outside the
    // printable/high ranges.
    function automatic logic byte_valid(input logic [7:0] b);
        return ((b >= 8'h20) && (b <= 8'h7E)) || (b >= 8'hA1) ||
               (b == HEAD_BYTE) || (b == TAIL_BYTE);
    endfunction

    state_t                    state_r, state_nx;
    logic [8*NUM_BLOCKS-1:0]   h_r, h_nx;
    logic [8*NUM_BLOCKS-1:0]   round_s;
    logic [7:0]                m_r, m_nx;
    logic [CW-1:0]             cnt_r, cnt_nx;
    logic [8*NUM_BLOCKS-1:0]   digest_r, digest_nx;
    logic                      digest_valid_r, digest_valid_nx;
    logic                      in_ready_r, in_ready_nx;
    logic                      busy_r, busy_nx;
    logic                      err_r, err_nx;
    logic                      accept_s;
    logic                      h_init_s;

    assign accept_s = in_valid && in_ready_r;

    // One full round: every lane reads the previous H, so all lanes update together.
    always_comb begin
        round_s = '0;
        for (int j = 0; j < NUM_BLOCKS; j++) begin
            round_s[8*j +: 8] = sbox(rotl8(h_r[8*((j + 2) % NUM_BLOCKS) +: 8] ^ m_r,
                                           3'(j % 8)));
        end
    end

    // Next-state and next-output logic of the framing/absorb FSM.
    always_comb begin
        state_nx        = state_r;
        h_nx            = h_r;
        m_nx            = m_r;
        cnt_nx          = cnt_r;
        digest_nx       = digest_r;
        digest_valid_nx = digest_valid_r;
        err_nx          = 1'b0;
        h_init_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !byte_valid(in_byte)) begin
                    err_nx   = 1'b1;
                    h_init_s = 1'b1;
                    h_nx     = INIT_VALUE;
                end else if (accept_s && (in_byte == HEAD_BYTE)) begin
                    h_init_s = 1'b1;
                    h_nx     = INIT_VALUE;
                    state_nx = ST_OPEN;
                end else begin
                    // Valid data or tail bytes outside a message are dropped.
                    state_nx = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (!accept_s) begin
                    state_nx = ST_OPEN;
                end else if (!byte_valid(in_byte)) begin
                    err_nx   = 1'b1;
                    h_init_s = 1'b1;
                    h_nx     = INIT_VALUE;
                    state_nx = ST_IDLE;
                end else if (in_byte == HEAD_BYTE) begin
                    h_init_s = 1'b1;
                    h_nx     = INIT_VALUE;
                    state_nx = ST_OPEN;
                end else if (in_byte == TAIL_BYTE) begin
                    digest_nx       = h_r;
                    digest_valid_nx = 1'b1;
                    state_nx        = ST_DONE;
                end else begin
                    m_nx     = in_byte;
                    cnt_nx   = '0;
                    state_nx = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                h_nx   = round_s;
                cnt_nx = cnt_r + CW'(1);
                if (cnt_r == LAST_CNT) begin
                    state_nx = ST_OPEN;
                end else begin
                    state_nx = ST_ABSORB;
                end
            end
            ST_DONE: begin
                if (digest_ack) begin
                    digest_nx       = '0;
                    digest_valid_nx = 1'b0;
                    h_init_s        = 1'b1;
                    h_nx            = INIT_VALUE;
                    state_nx        = ST_IDLE;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                digest_nx       = '0;
                digest_valid_nx = 1'b0;
                h_init_s        = 1'b1;
                h_nx            = INIT_VALUE;
                state_nx        = ST_IDLE;
            end
        endcase
        in_ready_nx = (state_nx == ST_IDLE) || (state_nx == ST_OPEN);
        busy_nx     = (state_nx == ST_ABSORB);
    end

    // State, hash lanes and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            h_r            <= INIT_VALUE;
            m_r            <= 8'h00;
            cnt_r          <= '0;
            digest_r       <= '0;
            digest_valid_r <= 1'b0;
            in_ready_r     <= 1'b0;
            busy_r         <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            state_r        <= state_nx;
            h_r            <= h_nx;
            m_r            <= m_nx;
            cnt_r          <= cnt_nx;
            digest_r       <= digest_nx;
            digest_valid_r <= digest_valid_nx;
            in_ready_r     <= in_ready_nx;
            busy_r         <= busy_nx;
            err_r          <= err_nx;
        end
    end

    assign in_ready         = in_ready_r;
    assign digest           = digest_r;
    assign digest_valid     = digest_valid_r;
    assign busy             = busy_r;
    assign err_invalid_byte = err_r;

`ifdef LH_MSG_LEN_EN
    logic [15:0] msg_len_r;

    // Data-byte counter: cleared whenever H is re-initialised, bumped when a
    // data byte enters ABSORB, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_len_r <= 16'h0000;
        end else if (h_init_s) begin
            msg_len_r <= 16'h0000;
        end else if ((state_r == ST_OPEN) && (state_nx == ST_ABSORB) &&
                     (msg_len_r != 16'hFFFF)) begin
            msg_len_r <= msg_len_r + 16'h0001;
        end else begin
            msg_len_r <= msg_len_r;
        end
    end

    assign msg_len = msg_len_r;
`endif

endmodule

// File: tb/tb_light_hash_param.sv
module tb_light_hash_param;

    localparam logic [7:0] HEAD = 8'hFF;
    localparam logic [7:0] TAIL = 8'h00;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          n;      // number of stream bytes
        logic [63:0] bytes;  // stream byte k at [8k+:8]
        bit          err;    // expect an invalid-byte pulse after the last byte
        logic [63:0] data;   // data bytes that should end up hashed
        int          dn;
        logic [63:0] exp;    // expected digest
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_byte_a = 8'h00, in_byte_b = 8'h00;
    logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic        ack_a = 1'b0, ack_b = 1'b0;
    logic        in_ready_a, in_ready_b, dv_a, dv_b, busy_a, busy_b, err_a, err_b;
    logic [63:0] digest_a;
    logic [31:0] digest_b;
`ifdef LH_MSG_LEN_EN
    logic [15:0] msg_len_a, msg_len_b;
`endif

    always #5 clk = ~clk;

    light_hash_param dut_a (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .digest(digest_a), .digest_valid(dv_a),
        .digest_ack(ack_a), .busy(busy_a), .err_invalid_byte(err_a)
`ifdef LH_MSG_LEN_EN
        , .msg_len(msg_len_a)
`endif
    );

    light_hash_param #(.NUM_BLOCKS(4), .ROUNDS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .digest(digest_b), .digest_valid(dv_b),
        .digest_ack(ack_b), .busy(busy_b), .err_invalid_byte(err_b)
`ifdef LH_MSG_LEN_EN
        , .msg_len(msg_len_b)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[256];
    vec_t       vt[14];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // S-box reference derived from GF(2^8) inversion plus the AES affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1B;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << (n % 8);
        return d[15:8];
    endfunction

    function automatic logic [127:0] model(input int nb, input int rounds, input bq_t msg);
        logic [7:0]   h[16];
        logic [7:0]   t[16];
        logic [127:0] r = '0;
        for (int j = 0; j < 16; j++) h[j] = 8'h00;
        foreach (msg[k]) begin
            for (int rr = 0; rr < rounds; rr++) begin
                for (int j = 0; j < nb; j++) t[j] = sb[rl8(h[(j + 2) % nb] ^ msg[k], j)];
                for (int j = 0; j < nb; j++) h[j] = t[j];
            end
        end
        for (int j = 0; j < nb; j++) r[8*j +: 8] = h[j];
        return r;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? in_ready_a : in_ready_b;
    endfunction

    task automatic send(input int sel, input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        while (!rdy(sel) && (w < 500)) begin
            @(negedge clk);
            w++;
        end
        if (!rdy(sel)) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, want 1", w);
            return;
        end
        if (sel == 0) begin in_byte_a = b; in_valid_a = 1'b1; end
        else          begin in_byte_b = b; in_valid_b = 1'b1; end
        @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic ack(input int sel);
        if (sel == 0) ack_a = 1'b1; else ack_b = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        ack_b = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bq_t          q;
        logic [63:0]  g41;
        logic [7:0]   inv, b;
        int           lowc, busy_bad, len;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
        end

        vt[0]  = '{2, 64'h00FF,             1'b0, 64'h0,    0, 64'h0};
        vt[1]  = '{3, 64'h0041FF,           1'b0, 64'h41,   1, 64'h0};
        vt[2]  = '{3, 64'h7F41FF,           1'b1, 64'h0,    0, 64'h0};
        vt[3]  = '{3, 64'h0041FF,           1'b0, 64'h41,   1, 64'h0};
        vt[4]  = '{5, 64'h0041FF61FF,       1'b0, 64'h41,   1, 64'h0};
        vt[5]  = '{6, 64'h007E20FF7E41,     1'b0, 64'h7E20, 2, 64'h0};
        vt[6]  = '{4, 64'h00B2A1FF,         1'b0, 64'hB2A1, 2, 64'h0};
        vt[7]  = '{2, 64'h10FF,             1'b1, 64'h0,    0, 64'h0};
        vt[8]  = '{2, 64'h80FF,             1'b1, 64'h0,    0, 64'h0};
        vt[9]  = '{2, 64'hA0FF,             1'b1, 64'h0,    0, 64'h0};
        vt[10] = '{4, 64'h0021FF00,         1'b0, 64'h21,   1, 64'h0};
        vt[11] = '{1, 64'h7F,               1'b1, 64'h0,    0, 64'h0};
        vt[12] = '{3, 64'h1F20FF,           1'b1, 64'h0,    0, 64'h0};
        vt[13] = '{4, 64'h00FE7EFF,         1'b0, 64'hFE7E, 2, 64'h0};
        for (int i = 0; i < 14; i++) begin
            q = {};
            for (int k = 0; k < vt[i].dn; k++) q.push_back(vt[i].data[8*k +: 8]);
            vt[i].exp = model(8, 32, q)[63:0];
        end
        q = {8'h41};
        g41 = model(8, 32, q)[63:0];

        // Reset values, including in_ready low during reset.
        #1;
        check("rst_in_ready", in_ready_a, 0);
        check("rst_digest", digest_a, 0);
        check("rst_digest_valid", dv_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_err", err_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready_a, 1);

        // HEAD,41,TAIL: in_ready low and busy high for exactly ROUNDS cycles.
        send(0, HEAD);
        send(0, 8'h41);
        lowc = 0;
        busy_bad = 0;
        while (!in_ready_a && (lowc < 100)) begin
            if (!busy_a) busy_bad++;
            lowc++;
            @(negedge clk);
        end
        check("ready_low_cycles", lowc, 32);
        check("busy_during_absorb", busy_bad, 0);
        check("busy_after_absorb", busy_a, 0);
        send(0, TAIL);
        check("s2_digest_valid", dv_a, 1);
        check("s2_digest", digest_a, g41);
        ack(0);
        check("s2_digest_cleared", digest_a, 0);

        // Table of framed streams.
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < vt[i].n; k++) send(0, vt[i].bytes[8*k +: 8]);
            if (vt[i].err) begin
                check($sformatf("v%0d_err_pulse", i), err_a, 1);
                @(negedge clk);
                check($sformatf("v%0d_err_single", i), err_a, 0);
                check($sformatf("v%0d_err_no_digest", i), dv_a, 0);
                check($sformatf("v%0d_err_idle_ready", i), in_ready_a, 1);
`ifdef LH_MSG_LEN_EN
                check($sformatf("v%0d_err_msg_len", i), msg_len_a, 0);
`endif
            end else begin
                check($sformatf("v%0d_digest_valid", i), dv_a, 1);
                check($sformatf("v%0d_digest", i), digest_a, vt[i].exp);
`ifdef LH_MSG_LEN_EN
                check($sformatf("v%0d_msg_len", i), msg_len_a, vt[i].dn);
`endif
                repeat (3) @(negedge clk);
                check($sformatf("v%0d_hold_valid", i), dv_a, 1);
                check($sformatf("v%0d_hold_digest", i), digest_a, vt[i].exp);
                check($sformatf("v%0d_done_ready", i), in_ready_a, 0);
                ack(0);
                check($sformatf("v%0d_ack_valid", i), dv_a, 0);
                check($sformatf("v%0d_ack_digest", i), digest_a, 0);
            end
        end

        // Reset 10 cycles into ABSORB.
        send(0, HEAD);
        send(0, 8'h41);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("absorb_rst_in_ready", in_ready_a, 0);
        check("absorb_rst_busy", busy_a, 0);
        check("absorb_rst_valid", dv_a, 0);
        check("absorb_rst_digest", digest_a, 0);
        check("absorb_rst_err", err_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("absorb_rst_ready_back", in_ready_a, 1);
        // Reset while in DONE.
        send(0, HEAD);
        send(0, TAIL);
        check("done_valid_before_rst", dv_a, 1);
        rst_n = 1'b0;
        #1;
        check("done_rst_valid", dv_a, 0);
        check("done_rst_digest", digest_a, 0);
        check("done_rst_in_ready", in_ready_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, HEAD);
        send(0, 8'h41);
        send(0, TAIL);
        check("after_rst_digest", digest_a, g41);
        ack(0);

        // NUM_BLOCKS=4, ROUNDS=4: random messages with gaps and late acks.
        for (int m = 0; m < 200; m++) begin
            q = {};
            len = $urandom_range(0, 20);
            send(1, HEAD);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 1) == 0) b = 8'($urandom_range(8'h20, 8'h7E));
                else                           b = 8'($urandom_range(8'hA1, 8'hFE));
                q.push_back(b);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(1, b);
            end
            send(1, TAIL);
            check($sformatf("r%0d_valid", m), dv_b, 1);
            check($sformatf("r%0d_digest", m), digest_b, model(4, 4, q)[31:0]);
`ifdef LH_MSG_LEN_EN
            check($sformatf("r%0d_msg_len", m), msg_len_b, len);
`endif
            repeat ($urandom_range(0, 4)) @(negedge clk);
            check($sformatf("r%0d_held", m), digest_b, model(4, 4, q)[31:0]);
            ack(1);
            check($sformatf("r%0d_cleared", m), dv_b, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
